// File: rtl/source_ram_pkg.sv
// Shared constants and read-FSM state type for the source packet RAM bank.
// Lane parity (macro SOURCE_RAM_PARITY_EN) uses PAR_LANE_W-bit lanes.
package source_ram_pkg;

    localparam int DEF_DATA_W    = 128;
    localparam int DEF_ADDR_W    = 9;
    localparam int DEF_PKT_WORDS = 128;
    localparam int PAR_LANE_W    = 32;

    typedef enum logic [1:0] {
        R_IDLE,
        R_RUN,
        R_DRAIN
    } rd_state_e;

endpackage

// File: rtl/source_ram_sp.sv
// Generic single-port RAM with a 1-cycle registered read.
// No reset: contents and q are undefined until written/read.
module source_ram_sp #(
    parameter int WIDTH  = 128,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic [WIDTH-1:0]  data,
    input  logic              wren,
    input  logic              rden,
    input  logic [ADDR_W-1:0] address,
    output logic [WIDTH-1:0]  q
);

    logic [WIDTH-1:0] mem [2 ** ADDR_W];
    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk) begin
        if (wren) begin
            mem[address] <= data;
        end
        if (rden) begin
            q_q <= mem[address];
        end
    end

    assign q = q_q;

endmodule

// File: rtl/source_ram_bank.sv
// Packet store: NUM_BANK single-port banks, filled in order, read per packet.
// Define SOURCE_RAM_PARITY_EN to add per-32-bit-lane even parity and par_err.
module source_ram_bank
    import source_ram_pkg::*;
#(
    parameter int NUM_BANK  = 3,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int PKT_WORDS = DEF_PKT_WORDS,
    localparam int TOTAL_PKTS = NUM_BANK * ((2 ** ADDR_W) / PKT_WORDS),
    localparam int PIDX_W     = $clog2(TOTAL_PKTS + 1)
) (
    input  logic              ram_clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    input  logic              rd_start,
    input  logic [PIDX_W-1:0] rd_pkt,
    output logic              rd_busy,
    output logic              q_valid,
    output logic [DATA_W-1:0] q_data,
    output logic              q_last,
    output logic [PIDX_W-1:0] pkt_count,
    output logic              full,
    output logic              err,
    output logic              par_err
);

    localparam int WP_W   = $clog2(TOTAL_PKTS * PKT_WORDS);
    localparam int PW_W   = $clog2(PKT_WORDS);
    localparam int BANK_W = WP_W - ADDR_W;
`ifdef SOURCE_RAM_PARITY_EN
    localparam int NLANE  = DATA_W / PAR_LANE_W;
    localparam int RAM_W  = DATA_W + NLANE;
`else
    localparam int RAM_W  = DATA_W;
`endif

    logic [WP_W-1:0]   wp_q, wp_d;
    logic [PIDX_W-1:0] pkt_count_q, pkt_count_d;
    logic              err_q, err_d;
    rd_state_e         st_q, st_d;
    logic [WP_W-1:0]   rptr_q, rptr_d;
    logic [PW_W-1:0]   rcnt_q, rcnt_d;
    logic [BANK_W-1:0] rsel_q, rsel_d;
    logic              q_valid_q, q_valid_d;
    logic              q_last_q, q_last_d;

    logic              wr_fire, wr_end, conflict, issue;
    logic [BANK_W-1:0] wbank, rbank;
    logic [RAM_W-1:0]  wr_word, rd_word;
    logic [RAM_W-1:0]  bank_q [NUM_BANK];

    assign full     = (pkt_count_q == PIDX_W'(TOTAL_PKTS));
    assign wr_ready = !full && !clr;
    assign wr_fire  = wr_valid && wr_ready;
    assign wr_end   = &wp_q[PW_W-1:0];
    assign wbank    = wp_q[WP_W-1:ADDR_W];
    assign rbank    = rptr_q[WP_W-1:ADDR_W];
    // The write owns a bank's only port; a read to it waits a cycle.
    assign conflict = wr_fire && (wbank == rbank);
    assign issue    = (st_q == R_RUN) && !conflict && !clr;

`ifdef SOURCE_RAM_PARITY_EN
    function automatic logic [NLANE-1:0] lane_par(input logic [DATA_W-1:0] d);
        for (int i = 0; i < NLANE; i++) begin
            lane_par[i] = ^d[i*PAR_LANE_W +: PAR_LANE_W];
        end
    endfunction

    logic par_err_q, par_err_d, par_bad;

    assign wr_word = {lane_par(wr_data), wr_data};
    assign par_bad = lane_par(rd_word[DATA_W-1:0]) != rd_word[RAM_W-1:DATA_W];
    assign par_err = par_err_q;
`else
    assign wr_word = wr_data;
    assign par_err = 1'b0;
`endif

    always_comb begin
        wp_d        = wp_q;
        pkt_count_d = pkt_count_q;
        err_d       = err_q;
        st_d        = st_q;
        rptr_d      = rptr_q;
        rcnt_d      = rcnt_q;
        rsel_d      = rbank;
        q_valid_d   = issue;
        q_last_d    = issue && (&rcnt_q);
`ifdef SOURCE_RAM_PARITY_EN
        par_err_d   = par_err_q || (q_valid_q && par_bad);
`endif
        if (wr_fire) begin
            if (wr_end || wr_last) begin
                // Close the slot and skip to the next packet boundary.
                wp_d        = {wp_q[WP_W-1:PW_W], PW_W'(0)} + WP_W'(PKT_WORDS);
                pkt_count_d = pkt_count_q + PIDX_W'(1);
                if (wr_end != wr_last) begin
                    err_d = 1'b1;
                end
            end else begin
                wp_d = wp_q + WP_W'(1);
            end
        end
        unique case (st_q)
            R_IDLE: begin
                if (rd_start) begin
                    if (rd_pkt < pkt_count_q) begin
                        rptr_d = WP_W'(rd_pkt) << PW_W;
                        rcnt_d = '0;
                        st_d   = R_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            R_RUN: begin
                if (issue) begin
                    rptr_d = rptr_q + WP_W'(1);
                    rcnt_d = rcnt_q + PW_W'(1);
                    if (&rcnt_q) begin
                        st_d = R_DRAIN;
                    end
                end
            end
            R_DRAIN: st_d = R_IDLE;
            default: st_d = R_IDLE;
        endcase
        if (clr) begin
            wp_d        = '0;
            pkt_count_d = '0;
            err_d       = 1'b0;
            st_d        = R_IDLE;
            rptr_d      = '0;
            rcnt_d      = '0;
            rsel_d      = '0;
            q_valid_d   = 1'b0;
            q_last_d    = 1'b0;
`ifdef SOURCE_RAM_PARITY_EN
            par_err_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge ram_clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q        <= '0;
            pkt_count_q <= '0;
            err_q       <= 1'b0;
            st_q        <= R_IDLE;
            rptr_q      <= '0;
            rcnt_q      <= '0;
            rsel_q      <= '0;
            q_valid_q   <= 1'b0;
            q_last_q    <= 1'b0;
`ifdef SOURCE_RAM_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            wp_q        <= wp_d;
            pkt_count_q <= pkt_count_d;
            err_q       <= err_d;
            st_q        <= st_d;
            rptr_q      <= rptr_d;
            rcnt_q      <= rcnt_d;
            rsel_q      <= rsel_d;
            q_valid_q   <= q_valid_d;
            q_last_q    <= q_last_d;
`ifdef SOURCE_RAM_PARITY_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
        logic wsel, rsel;
        assign wsel = wr_fire && (wbank == BANK_W'(b));
        assign rsel = issue && (rbank == BANK_W'(b));
        source_ram_sp #(
            .WIDTH  (RAM_W),
            .ADDR_W (ADDR_W)
        ) u_ram (
            .clk     (ram_clk),
            .data    (wr_word),
            .wren    (wsel),
            .rden    (rsel),
            .address (wsel ? wp_q[ADDR_W-1:0] : rptr_q[ADDR_W-1:0]),
            .q       (bank_q[b])
        );
    end

    assign rd_word   = bank_q[rsel_q];
    assign q_data    = q_valid_q ? rd_word[DATA_W-1:0] : '0;
    assign q_valid   = q_valid_q;
    assign q_last    = q_last_q;
    assign rd_busy   = (st_q != R_IDLE);
    assign pkt_count = pkt_count_q;
    assign err       = err_q;

endmodule

// File: tb/tb_source_ram_bank.sv
// Directed bench for source_ram_bank (3 banks, 12 packets of 128 words).
// Define SOURCE_RAM_PARITY_EN to also exercise the parity backdoor case.
module tb_source_ram_bank;

    logic         clk = 1'b0;
    logic         rst_n, clr;
    logic         wr_valid, wr_ready, wr_last;
    logic [127:0] wr_data;
    logic         rd_start, rd_busy;
    logic [3:0]   rd_pkt;
    logic         q_valid, q_last;
    logic [127:0] q_data;
    logic [3:0]   pkt_count;
    logic         full, err, par_err;

    int tests = 0;
    int fails = 0;

    logic [127:0] got [$];
    int gaps, last_cnt, last_pos;

    always #5 clk = ~clk;

    source_ram_bank dut (
        .ram_clk   (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .wr_last   (wr_last),
        .rd_start  (rd_start),
        .rd_pkt    (rd_pkt),
        .rd_busy   (rd_busy),
        .q_valid   (q_valid),
        .q_data    (q_data),
        .q_last    (q_last),
        .pkt_count (pkt_count),
        .full      (full),
        .err       (err),
        .par_err   (par_err)
    );

    always @(negedge clk) begin
        if (q_valid) begin
            got.push_back(q_data);
            if (q_last) begin
                last_cnt++;
                last_pos = got.size() - 1;
            end
        end else if (rd_busy && got.size() > 0) begin
            gaps++;
        end
    end

    task automatic check(input string tag, input logic [127:0] act,
                         input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic mon_clear();
        got.delete();
        gaps     = 0;
        last_cnt = 0;
        last_pos = -1;
    endtask

    function automatic int bad_words(input int base, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            if (i >= got.size() || got[i] !== 128'(base + i)) begin
                bad++;
            end
        end
        return bad;
    endfunction

    task automatic wr_word(input int d, input logic last);
        wr_valid = 1'b1;
        wr_data  = 128'(d);
        wr_last  = last;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic wr_pkt(input int base, input int n, input logic last_ok);
        for (int i = 0; i < n; i++) begin
            wr_word(base + i, last_ok && (i == n - 1));
        end
    endtask

    task automatic start_read(input int p);
        rd_start = 1'b1;
        rd_pkt   = 4'(p);
        @(posedge clk);
        #1;
        rd_start = 1'b0;
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic wait_rd_done(input string tag);
        int n = 0;
        @(negedge clk);
        #1;
        while (rd_busy && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, 128'(n < 500), 128'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_seen;
        int n;
        int n_before;
        rst_n    = 1'b0;
        clr      = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        wr_last  = 1'b0;
        rd_start = 1'b0;
        rd_pkt   = '0;
        mon_clear();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_wr_ready", 128'(wr_ready), 128'(1));
        check("rst_rd_busy", 128'(rd_busy), 128'(0));
        check("rst_q_valid", 128'(q_valid), 128'(0));
        check("rst_q_last", 128'(q_last), 128'(0));
        check("rst_q_data", q_data, 128'(0));
        check("rst_pkt_count", 128'(pkt_count), 128'(0));
        check("rst_full", 128'(full), 128'(0));
        check("rst_err", 128'(err), 128'(0));
        check("rst_par_err", 128'(par_err), 128'(0));

        // Fill all 12 packets with word k = k, then read packet 5.
        @(posedge clk);
        #1;
        for (int p = 0; p < 12; p++) begin
            wr_pkt(p * 128, 128, 1'b1);
        end
        check("fill_pkt_count", 128'(pkt_count), 128'(12));
        check("fill_full", 128'(full), 128'(1));
        check("fill_wr_ready", 128'(wr_ready), 128'(0));
        check("fill_err", 128'(err), 128'(0));
        mon_clear();
        start_read(5);
        wait_rd_done("p5_timeout");
        check("p5_words", 128'(got.size()), 128'(128));
        check("p5_data_bad", 128'(bad_words(640, 128)), 128'(0));
        check("p5_last_cnt", 128'(last_cnt), 128'(1));
        check("p5_last_pos", 128'(last_pos), 128'(127));
        check("p5_gaps", 128'(gaps), 128'(0));

        // Early wr_last on the 60th word.
        clr_pulse();
        check("clr_pkt_count", 128'(pkt_count), 128'(0));
        check("clr_full", 128'(full), 128'(0));
        wr_pkt(0, 60, 1'b1);
        check("early_err", 128'(err), 128'(1));
        check("early_pkt_count", 128'(pkt_count), 128'(1));
        wr_pkt(1000, 128, 1'b1);
        check("early_pkt_count2", 128'(pkt_count), 128'(2));
        mon_clear();
        start_read(1);
        wait_rd_done("early_p1_timeout");
        check("early_p1_first", got.size() > 0 ? got[0] : 128'hx, 128'(1000));
        check("early_p1_data_bad", 128'(bad_words(1000, 128)), 128'(0));
        mon_clear();
        start_read(0);
        wait_rd_done("early_p0_timeout");
        check("early_p0_words", 128'(got.size()), 128'(128));
        check("early_p0_data_bad", 128'(bad_words(0, 60)), 128'(0));

        // 128th word without wr_last still closes, with err.
        clr_pulse();
        check("clr_err", 128'(err), 128'(0));
        wr_pkt(0, 128, 1'b0);
        check("nolast_pkt_count", 128'(pkt_count), 128'(1));
        check("nolast_err", 128'(err), 128'(1));

        // Read pkt 0 while writing pkt 1 into the same bank.
        clr_pulse();
        wr_pkt(0, 128, 1'b1);
        check("good_err", 128'(err), 128'(0));
        mon_clear();
        start_read(0);
        repeat (5) @(posedge clk);
        #1;
        wr_pkt(500, 128, 1'b1);
        wait_rd_done("conf_timeout");
        check("conf_words", 128'(got.size()), 128'(128));
        check("conf_data_bad", 128'(bad_words(0, 128)), 128'(0));
        check("conf_gaps", 128'(gaps), 128'(128));
        check("conf_last_cnt", 128'(last_cnt), 128'(1));
        check("conf_pkt_count", 128'(pkt_count), 128'(2));
        mon_clear();
        start_read(1);
        wait_rd_done("conf_p1_timeout");
        check("conf_p1_data_bad", 128'(bad_words(500, 128)), 128'(0));

        // Out-of-range read request.
        mon_clear();
        busy_seen = 0;
        start_read(3);
        repeat (4) begin
            @(negedge clk);
            if (rd_busy) busy_seen = 1;
        end
        check("oor_busy", 128'(busy_seen), 128'(0));
        check("oor_words", 128'(got.size()), 128'(0));
        check("oor_err", 128'(err), 128'(1));

        // Async reset in the middle of a read.
        mon_clear();
        start_read(1);
        n = 0;
        while (got.size() < 40 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("mid_wait", 128'(n < 300), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        n_before = got.size();
        check("mid_q_valid", 128'(q_valid), 128'(0));
        check("mid_q_last", 128'(q_last), 128'(0));
        check("mid_q_data", q_data, 128'(0));
        check("mid_rd_busy", 128'(rd_busy), 128'(0));
        check("mid_pkt_count", 128'(pkt_count), 128'(0));
        check("mid_err", 128'(err), 128'(0));
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("post_pkt_count", 128'(pkt_count), 128'(0));
        check("post_words", 128'(got.size()), 128'(n_before));
        check("post_last_cnt", 128'(last_cnt), 128'(0));

        // Parity: corrupt one stored bit, then read the packet back.
        @(posedge clk);
        #1;
        wr_pkt(0, 128, 1'b1);
`ifdef SOURCE_RAM_PARITY_EN
        dut.g_bank[0].u_ram.mem[3][5] = ~dut.g_bank[0].u_ram.mem[3][5];
`endif
        mon_clear();
        start_read(0);
        wait_rd_done("par_timeout");
        check("par_words", 128'(got.size()), 128'(128));
`ifdef SOURCE_RAM_PARITY_EN
        check("par_err_set", 128'(par_err), 128'(1));
        clr_pulse();
        check("par_err_clr", 128'(par_err), 128'(0));
`else
        check("par_data_bad", 128'(bad_words(0, 128)), 128'(0));
        check("par_err_tied", 128'(par_err), 128'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
